// File: rtl/grid_memory.sv
// Snake-game board store: 32x24 grid of 4-bit cell codes with a combinational controller
// read port, a registered renderer read port, and a power-up/clear sweep.
module grid_memory #(
    parameter int unsigned GRID_X      = 32,
    parameter int unsigned GRID_Y      = 24,
    parameter int unsigned CELL_SHIFT  = 5,
    parameter int unsigned BORDER_ROCK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [35:0] wr_cmd,
    input  logic [31:0] rd_addr,
    output logic [3:0]  rd_cell,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic [3:0]  pix_cell,
    output logic        busy
);

    localparam int unsigned XW    = $clog2(GRID_X);
    localparam int unsigned YW    = $clog2(GRID_Y);
    localparam int unsigned AW    = XW + YW;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CELLS = GRID_X * GRID_Y;

    localparam logic [3:0] CODE_NULL = 4'b0000;
    localparam logic [3:0] CODE_ROCK = 4'b0010;

    localparam logic [15:0]   GRID_X16  = 16'(GRID_X);
    localparam logic [15:0]   GRID_Y16  = 16'(GRID_Y);
    localparam logic [10:0]   PIX_W     = 11'(GRID_X << CELL_SHIFT);
    localparam logic [10:0]   PIX_H     = 11'(GRID_Y << CELL_SHIFT);
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(GRID_X - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(GRID_Y - 1);

    typedef enum logic [0:0] {StSweep, StIdle} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic [3:0]      pix_cell_q, pix_cell_d;
    logic [3:0]      mem [DEPTH];

    logic [15:0]     wr_x, wr_y, rd_x, rd_y;
    logic [3:0]      wr_code;
    logic            wr_in_range, rd_in_range, pix_in_range;
    logic [XW-1:0]   sweep_x;
    logic [YW-1:0]   sweep_y;
    logic            on_border;
    logic [3:0]      sweep_code;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [3:0]      mem_wdata;
    logic [AW-1:0]   rd_idx, pix_idx;

    assign wr_x    = wr_cmd[35:20];
    assign wr_y    = wr_cmd[19:4];
    assign wr_code = wr_cmd[3:0];
    assign rd_x    = rd_addr[31:16];
    assign rd_y    = rd_addr[15:0];

    // Full-width compares so wrapped values like 16'hFFFF never alias onto the board.
    assign wr_in_range  = (wr_x < GRID_X16) && (wr_y < GRID_Y16);
    assign rd_in_range  = (rd_x < GRID_X16) && (rd_y < GRID_Y16);
    assign pix_in_range = (pix_x < PIX_W) && (pix_y < PIX_H);

    assign rd_idx  = {rd_y[YW-1:0], rd_x[XW-1:0]};
    assign pix_idx = {pix_y[CELL_SHIFT +: YW], pix_x[CELL_SHIFT +: XW]};

    // Counter is the array address directly: x in the low bits walks fastest.
    assign sweep_x    = sweep_cnt_q[XW-1:0];
    assign sweep_y    = sweep_cnt_q[AW-1:XW];
    assign on_border  = (sweep_x == '0) || (sweep_x == X_LAST) ||
                        (sweep_y == '0) || (sweep_y == Y_LAST);
    assign sweep_code = ((BORDER_ROCK != 0) && on_border) ? CODE_ROCK : CODE_NULL;

    assign busy     = (state_q == StSweep);
    assign pix_cell = pix_cell_q;

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        unique case (state_q)
            StSweep: begin
                if (clr) begin
                    sweep_cnt_d = '0;
                end else if (sweep_cnt_q == LAST_CELL) begin
                    state_d     = StIdle;
                    sweep_cnt_d = '0;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d     = StSweep;
                    sweep_cnt_d = '0;
                end
            end
            default: begin
                state_d     = StSweep;
                sweep_cnt_d = '0;
            end
        endcase
    end

    // Single write port: the sweep owns it while busy, the controller otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sweep_cnt_q;
        mem_wdata = sweep_code;
        if (busy) begin
            mem_we = 1'b1;
        end else if (wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_y[YW-1:0], wr_x[XW-1:0]};
            mem_wdata = wr_code;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Off-board and mid-sweep lookups read as wall so the controller never steers into them.
    always_comb begin
        rd_cell = CODE_ROCK;
        if (!busy && rd_in_range) begin
            rd_cell = mem[rd_idx];
        end
    end

    always_comb begin
        pix_cell_d = CODE_NULL;
        if (!busy && pix_in_range) begin
            pix_cell_d = mem[pix_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSweep;
            sweep_cnt_q <= '0;
            pix_cell_q  <= CODE_NULL;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            pix_cell_q  <= pix_cell_d;
        end
    end

endmodule

// File: tb/tb_grid_memory.sv
// Randomised bench for grid_memory: a board-level reference model feeds expected values into
// queues that a negedge monitor drains against the DUT outputs.
module tb_grid_memory;

    localparam int GX    = 32;
    localparam int GY    = 24;
    localparam int CELLS = GX * GY;

    localparam logic [3:0]  C_NULL  = 4'b0000;
    localparam logic [3:0]  C_SNAKE = 4'b0001;
    localparam logic [3:0]  C_ROCK  = 4'b0010;
    localparam logic [3:0]  C_SNACK = 4'b0100;
    localparam logic [35:0] NOP     = {16'hFFFF, 16'hFFFF, 4'h0};

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [35:0] wr_cmd;
    logic [31:0] rd_addr;
    logic [3:0]  rd_cell;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic [3:0]  pix_cell;
    logic        busy;

    always #5 clk = ~clk;

    grid_memory dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_cmd   (wr_cmd),
        .rd_addr  (rd_addr),
        .rd_cell  (rd_cell),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_cell (pix_cell),
        .busy     (busy)
    );

    // kind: 0 = rd_cell, 1 = busy, 2 = pix_cell
    typedef struct {
        int         due;
        int         kind;
        logic [3:0] val;
    } exp_t;

    exp_t comb_q[$];
    exp_t pix_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0] board [GY][GX];
    int         sweep_left;

    task automatic init_board();
        for (int y = 0; y < GY; y++) begin
            for (int x = 0; x < GX; x++) begin
                board[y][x] = (x == 0 || x == GX - 1 || y == 0 || y == GY - 1) ? C_ROCK : C_NULL;
            end
        end
    endtask

    task automatic step(input logic [35:0] w, input logic [31:0] ra, input logic [10:0] px,
                        input logic [10:0] py, input logic c, input logic r);
        int         wx, wy, rx, ry;
        logic [3:0] rd_exp, pix_exp;
        @(posedge clk);
        #1;
        wr_cmd  = w;
        rd_addr = ra;
        pix_x   = px;
        pix_y   = py;
        clr     = c;
        rst     = r;
        cyc++;
        wx = int'(w[35:20]);
        wy = int'(w[19:4]);
        rx = int'(ra[31:16]);
        ry = int'(ra[15:0]);
        if (r) begin
            sweep_left = CELLS;
            pix_q.delete();
            pix_q.push_back('{due: cyc, kind: 2, val: 4'h0});
            comb_q.push_back('{due: cyc, kind: 1, val: 4'h1});
            comb_q.push_back('{due: cyc, kind: 0, val: C_ROCK});
            pix_q.push_back('{due: cyc + 1, kind: 2, val: 4'h0});
        end else begin
            if (sweep_left > 0 || rx >= GX || ry >= GY) rd_exp = C_ROCK;
            else rd_exp = board[ry][rx];
            if (sweep_left > 0 || int'(px) >= GX * 32 || int'(py) >= GY * 32) pix_exp = C_NULL;
            else pix_exp = board[int'(py) / 32][int'(px) / 32];
            comb_q.push_back('{due: cyc, kind: 1, val: (sweep_left > 0) ? 4'h1 : 4'h0});
            comb_q.push_back('{due: cyc, kind: 0, val: rd_exp});
            pix_q.push_back('{due: cyc + 1, kind: 2, val: pix_exp});
            // Clock edge effect on the board
            if (sweep_left > 0) begin
                if (c) begin
                    sweep_left = CELLS;
                end else begin
                    sweep_left--;
                    if (sweep_left == 0) init_board();
                end
            end else begin
                if (wx < GX && wy < GY) board[wy][wx] = w[3:0];
                if (c) sweep_left = CELLS;
            end
        end
    endtask

    function automatic logic [35:0] rand_wr();
        int         sel  = int'($urandom_range(0, 99));
        logic [3:0] code = 4'($urandom_range(0, 15));
        logic [15:0] x   = 16'($urandom_range(0, GX - 1));
        logic [15:0] y   = 16'($urandom_range(0, GY - 1));
        if (sel >= 80) return NOP;
        if (sel >= 60) begin
            case ($urandom_range(0, 3))
                0: x = 16'($urandom_range(GX, 65535));
                1: y = 16'($urandom_range(GY, 65535));
                2: x = 16'hFFFF;
                default: y = 16'(GY);
            endcase
        end
        return {x, y, code};
    endfunction

    function automatic logic [31:0] rand_rd();
        int          sel = int'($urandom_range(0, 99));
        logic [15:0] x   = 16'($urandom_range(0, GX - 1));
        logic [15:0] y   = 16'($urandom_range(0, GY - 1));
        if (sel >= 95) x = 16'hFFFF;
        else if (sel >= 90) x = 16'($urandom_range(GX, 2 * GX - 1));
        else if (sel >= 85) y = 16'($urandom_range(GY, 31));
        return {x, y};
    endfunction

    task automatic rand_step(input logic r);
        step(rand_wr(), rand_rd(), 11'($urandom_range(0, 1100)), 11'($urandom_range(0, 800)),
             1'b0, r);
    endtask

    task automatic run_sweep_out();
        for (int i = 0; i < 2 * CELLS && sweep_left > 0; i++) rand_step(1'b0);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] act;
        string      nm;
        forever begin
            @(negedge clk);
            while (comb_q.size() > 0 && comb_q[0].due <= cyc) begin
                e   = comb_q.pop_front();
                act = (e.kind == 0) ? rd_cell : {3'b000, busy};
                nm  = (e.kind == 0) ? "rd_cell" : "busy";
                n_cmp++;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d rd_addr=%h got=%h expected=%h", nm, cyc, rd_addr,
                             act, e.val);
                end
            end
            while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
                e = pix_q.pop_front();
                n_cmp++;
                if (pix_cell !== e.val) begin
                    n_err++;
                    $display("FAIL pix_cell cyc=%0d got=%h expected=%h", cyc, pix_cell, e.val);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "time limit");
    end

    initial begin : stim
        rst     = 1'b1;
        clr     = 1'b0;
        wr_cmd  = NOP;
        rd_addr = '0;
        pix_x   = '0;
        pix_y   = '0;
        sweep_left = CELLS;

        step(NOP, 32'h0, 11'd0, 11'd0, 1'b0, 1'b1);
        run_sweep_out();

        // Border and interior after the power-up sweep
        step(NOP, {16'd0, 16'd5}, 11'd0, 11'd0, 1'b0, 1'b0);
        step(NOP, {16'd15, 16'd15}, 11'd1000, 11'd760, 1'b0, 1'b0);
        step(NOP, {16'd31, 16'd23}, 11'd1024, 11'd100, 1'b0, 1'b0);

        // Controller write then both read ports
        step({16'd15, 16'd15, C_SNAKE}, {16'd15, 16'd15}, 11'd480, 11'd480, 1'b0, 1'b0);
        step(NOP, {16'd15, 16'd15}, 11'd480, 11'd480, 1'b0, 1'b0);
        step(NOP, {16'd15, 16'd15}, 11'd480, 11'd768, 1'b0, 1'b0);

        // Out-of-range writes must not alias onto real cells
        step({16'hFFFF, 16'd3, C_SNACK}, {16'hFFFF, 16'd3}, 11'd992, 11'd96, 1'b0, 1'b0);
        step({16'd5, 16'd24, C_SNACK}, {16'd5, 16'd24}, 11'd160, 11'd736, 1'b0, 1'b0);
        step({16'd39, 16'd7, C_SNACK}, {16'd31, 16'd3}, 11'd224, 11'd224, 1'b0, 1'b0);
        step(NOP, {16'd7, 16'd7}, 11'd224, 11'd224, 1'b0, 1'b0);

        // Same-cycle read/write returns old contents
        step({16'd7, 16'd7, C_SNACK}, {16'd7, 16'd7}, 11'd224, 11'd224, 1'b0, 1'b0);
        step(NOP, {16'd7, 16'd7}, 11'd224, 11'd224, 1'b0, 1'b0);
        step(NOP, {16'd7, 16'd7}, 11'd230, 11'd250, 1'b0, 1'b0);

        repeat (1500) rand_step(1'b0);

        // Clear with writes attempted during the sweep
        step(NOP, {16'd15, 16'd15}, 11'd480, 11'd480, 1'b1, 1'b0);
        run_sweep_out();
        step(NOP, {16'd15, 16'd15}, 11'd480, 11'd480, 1'b0, 1'b0);
        repeat (400) rand_step(1'b0);

        // Clear re-issued mid-sweep restarts the count
        step(NOP, {16'd3, 16'd3}, 11'd96, 11'd96, 1'b1, 1'b0);
        for (int i = 0; i < CELLS && (CELLS - sweep_left) < 400; i++) rand_step(1'b0);
        step(rand_wr(), rand_rd(), 11'd480, 11'd480, 1'b1, 1'b0);
        run_sweep_out();
        repeat (400) rand_step(1'b0);

        // Reset in the middle of a sweep
        step(NOP, {16'd3, 16'd3}, 11'd96, 11'd96, 1'b1, 1'b0);
        for (int i = 0; i < CELLS && (CELLS - sweep_left) < 100; i++) rand_step(1'b0);
        rand_step(1'b1);
        rand_step(1'b1);
        run_sweep_out();
        repeat (400) rand_step(1'b0);

        step(NOP, 32'h0, 11'd0, 11'd0, 1'b0, 1'b0);
        step(NOP, 32'h0, 11'd0, 11'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
